// File: rtl/exc_pc_ctrl.sv
// Exception/return controller for the unpipelined core: EPC/CAUSE/STATUS, RUN/HANDLER FSM, next-PC select.
// Optional macro VECTORED_EXC_EN: handler address = HANDLER_ADDR + (ExcCode << 4) instead of a single entry.
module exc_pc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
    parameter int          NUM_IRQ      = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [31:0]        i_fetch_pc,
    input  logic [31:0]        i_fetch_instr,
    input  logic               i_branch_taken,
    input  logic [31:0]        i_branch_target,
    input  logic               i_ovf,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic               i_status_we,
    input  logic [31:0]        i_status_wdata,
    output logic [1:0]         o_pcsrc,
    output logic [31:0]        o_execute,
    output logic [31:0]        o_epc,
    output logic [31:0]        o_error_handler,
    output logic [31:0]        o_cause,
    output logic [31:0]        o_status,
    output logic               o_in_handler
);

    typedef enum logic {
        ST_RUN,
        ST_HANDLER
    } state_t;

    localparam logic [4:0]  EXC_INT  = 5'd0;
    localparam logic [4:0]  EXC_SYS  = 5'd8;
    localparam logic [4:0]  EXC_OVF  = 5'd12;
    localparam logic [31:0] ERET_OP  = 32'h4200_0018;

    state_t             state_q, state_d;
    logic [31:0]        epc_q;
    logic [4:0]         exc_code_q;
    logic               ie_q;
    logic               exl_q;
    logic [7:0]         im_q;
    logic [NUM_IRQ-1:0] irq_q;

    logic       is_syscall;
    logic       is_eret;
    logic       in_handler;
    logic       irq_pending;
    logic       irq_take;
    logic       take_exc;
    logic       eret_return;
    logic [4:0] exc_code_now;

    logic unused_wdata;
    assign unused_wdata = ^{i_status_wdata[31:16], i_status_wdata[7:1]};

    assign is_syscall  = (i_fetch_instr[31:26] == 6'd0) && (i_fetch_instr[5:0] == 6'h0C);
    assign is_eret     = (i_fetch_instr == ERET_OP);
    assign in_handler  = (state_q == ST_HANDLER);

    // Interrupts are level-held: a blocked cycle simply leaves them pending for the next one.
    assign irq_pending = (|(irq_q & im_q[NUM_IRQ-1:0])) & ie_q & ~in_handler;
    assign irq_take    = irq_pending & ~is_eret & ~i_branch_taken & ~i_ovf & ~is_syscall;
    assign take_exc    = i_ovf | is_syscall | irq_take;
    assign eret_return = is_eret & in_handler & ~i_ovf & ~is_syscall;

    always_comb begin
        exc_code_now = EXC_INT;
        if (i_ovf) begin
            exc_code_now = EXC_OVF;
        end else if (is_syscall) begin
            exc_code_now = EXC_SYS;
        end
    end

    always_comb begin
        state_d = state_q;
        o_pcsrc = 2'b00;
        if (take_exc) begin
            o_pcsrc = 2'b11;
            state_d = ST_HANDLER;
        end else if (eret_return) begin
            o_pcsrc = 2'b10;
            state_d = ST_RUN;
        end else if (i_branch_taken) begin
            o_pcsrc = 2'b01;
        end
    end

`ifdef VECTORED_EXC_EN
    assign o_error_handler = HANDLER_ADDR + ({27'd0, exc_code_now} << 4);
`else
    assign o_error_handler = HANDLER_ADDR;
`endif

    // A nested exception in HANDLER refreshes the cause but keeps the original return address.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_RUN;
            epc_q      <= '0;
            exc_code_q <= '0;
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            im_q       <= '0;
            irq_q      <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= i_irq;
            if (take_exc) begin
                exc_code_q <= exc_code_now;
                exl_q      <= 1'b1;
                if (!in_handler) begin
                    epc_q <= i_fetch_pc;
                end
            end else if (eret_return) begin
                exl_q <= 1'b0;
            end
            if (i_status_we) begin
                ie_q <= i_status_wdata[0];
                im_q <= i_status_wdata[15:8];
            end
        end
    end

    always_comb begin
        o_cause                  = '0;
        o_cause[6:2]             = exc_code_q;
        o_cause[8 +: NUM_IRQ]    = irq_q;
    end

    assign o_status     = {16'd0, im_q, 6'd0, exl_q, ie_q};
    assign o_epc        = epc_q;
    assign o_execute    = i_branch_target;
    assign o_in_handler = in_handler;

endmodule

// File: tb/tb_exc_pc_ctrl.sv
// Self-checking bench for exc_pc_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a behavioural model of the exception rules.
module tb_exc_pc_ctrl;

    localparam int NUM_IRQ = 4;

    logic               clk;
    logic               rst;
    logic [31:0]        fetch_pc;
    logic [31:0]        fetch_instr;
    logic               branch_taken;
    logic [31:0]        branch_target;
    logic               ovf;
    logic [NUM_IRQ-1:0] irq;
    logic               status_we;
    logic [31:0]        status_wdata;
    logic [1:0]         pcsrc;
    logic [31:0]        execute;
    logic [31:0]        epc;
    logic [31:0]        error_handler;
    logic [31:0]        cause;
    logic [31:0]        status;
    logic               in_handler;

    int checks = 0;
    int passes = 0;
    bit checking = 0;

    // Behavioural model state
    bit                 m_handler;
    logic [31:0]        m_epc;
    int                 m_code;
    bit                 m_ie;
    bit                 m_exl;
    logic [7:0]         m_im;
    logic [NUM_IRQ-1:0] m_irq_q;

    exc_pc_ctrl #(.HANDLER_ADDR(32'h0000_0080), .NUM_IRQ(NUM_IRQ)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_fetch_pc     (fetch_pc),
        .i_fetch_instr  (fetch_instr),
        .i_branch_taken (branch_taken),
        .i_branch_target(branch_target),
        .i_ovf          (ovf),
        .i_irq          (irq),
        .i_status_we    (status_we),
        .i_status_wdata (status_wdata),
        .o_pcsrc        (pcsrc),
        .o_execute      (execute),
        .o_epc          (epc),
        .o_error_handler(error_handler),
        .o_cause        (cause),
        .o_status       (status),
        .o_in_handler   (in_handler)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic bit m_is_syscall(logic [31:0] ins);
        return (ins[31:26] == 0) && (ins[5:0] == 6'h0C);
    endfunction

    function automatic bit m_is_eret(logic [31:0] ins);
        return ins == 32'h4200_0018;
    endfunction

    function automatic bit m_exc_now();
        bit irq_ok;
        irq_ok = m_ie && !m_handler && ((m_irq_q & m_im[NUM_IRQ-1:0]) != 0)
                 && !m_is_eret(fetch_instr) && !branch_taken;
        return ovf || m_is_syscall(fetch_instr) || irq_ok;
    endfunction

    function automatic int m_code_now();
        if (ovf) return 12;
        if (m_is_syscall(fetch_instr)) return 8;
        return 0;
    endfunction

    function automatic logic [1:0] m_pcsrc();
        if (m_exc_now()) return 2'd3;
        if (m_is_eret(fetch_instr) && m_handler) return 2'd2;
        if (branch_taken) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_handler_addr();
`ifdef VECTORED_EXC_EN
        return 32'h80 + 32'(m_code_now() * 16);
`else
        return 32'h80;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_handler = 0; m_epc = 0; m_code = 0; m_ie = 0; m_exl = 0; m_im = 0; m_irq_q = 0;
        end else begin
            bit exc;
            bit ret;
            exc = m_exc_now();
            ret = !exc && m_is_eret(fetch_instr) && m_handler;
            if (exc) begin
                m_code = m_code_now();
                if (!m_handler) m_epc = fetch_pc;
                m_handler = 1;
                m_exl = 1;
            end else if (ret) begin
                m_handler = 0;
                m_exl = 0;
            end
            if (status_we) begin
                m_ie = status_wdata[0];
                m_im = status_wdata[15:8];
            end
            m_irq_q = irq;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    endtask

    // Single compare process: every cycle, mid-low-phase, outputs vs model.
    always @(negedge clk) begin
        #2;
        if (checking) begin
            logic [1:0] exp_pc;
            exp_pc = m_pcsrc();
            checkOutput("model_pcsrc", {30'd0, pcsrc}, {30'd0, exp_pc});
            checkOutput("model_execute", execute, branch_target);
            checkOutput("model_epc", epc, m_epc);
            checkOutput("model_cause", cause, (m_code << 2) | (32'(m_irq_q) << 8));
            checkOutput("model_status", status, (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie));
            checkOutput("model_in_handler", {31'd0, in_handler}, {31'd0, m_handler});
            if (exp_pc == 2'd3) checkOutput("model_handler", error_handler, m_handler_addr());
        end
    end

    task automatic applyStimulus(input bit r, input logic [31:0] pc, input logic [31:0] ins,
                                 input bit br, input logic [31:0] tgt, input bit ov,
                                 input logic [NUM_IRQ-1:0] iq, input bit we, input logic [31:0] wd);
        @(negedge clk);
        rst = r; fetch_pc = pc; fetch_instr = ins; branch_taken = br; branch_target = tgt;
        ovf = ov; irq = iq; status_we = we; status_wdata = wd;
        #3;
    endtask

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] SYS  = 32'h0000_000C;
    localparam logic [31:0] ERET = 32'h4200_0018;

    initial begin
        rst = 1; fetch_pc = 0; fetch_instr = 0; branch_taken = 0; branch_target = 0;
        ovf = 0; irq = 0; status_we = 0; status_wdata = 0;

        applyStimulus(1, 0, NOP, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, NOP, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_pcsrc", {30'd0, pcsrc}, 0);
        checkOutput("reset_epc", epc, 0);
        checkOutput("reset_cause", cause, 0);
        checkOutput("reset_status", status, 0);
        checkOutput("reset_in_handler", {31'd0, in_handler}, 0);
        checking = 1;

        // Syscall then eret
        applyStimulus(0, 32'h10, SYS, 0, 32'h1234, 0, 0, 0, 0);
        checkOutput("sys_pcsrc", {30'd0, pcsrc}, 3);
`ifdef VECTORED_EXC_EN
        checkOutput("sys_handler", error_handler, 32'h100);
`else
        checkOutput("sys_handler", error_handler, 32'h80);
`endif
        applyStimulus(0, 32'h84, ERET, 0, 0, 0, 0, 0, 0);
        checkOutput("sys_epc", epc, 32'h10);
        checkOutput("sys_cause", cause, 32'h20);
        checkOutput("sys_in_handler", {31'd0, in_handler}, 1);
        checkOutput("eret_pcsrc", {30'd0, pcsrc}, 2);
        applyStimulus(0, 32'h14, NOP, 0, 0, 0, 0, 0, 0);
        checkOutput("eret_in_handler", {31'd0, in_handler}, 0);
        checkOutput("eret_status", status, 0);

        // Interrupt with IE and IM0 enabled
        applyStimulus(0, 32'h1C, NOP, 0, 0, 0, 4'b0001, 1, 32'h0101);
        checkOutput("irq_wait_pcsrc", {30'd0, pcsrc}, 0);
        applyStimulus(0, 32'h20, NOP, 0, 0, 0, 4'b0001, 0, 0);
        checkOutput("irq_pcsrc", {30'd0, pcsrc}, 3);
        checkOutput("irq_handler", error_handler, 32'h80);
        applyStimulus(0, 32'h80, NOP, 0, 0, 0, 4'b0001, 0, 0);
        checkOutput("irq_epc", epc, 32'h20);
        checkOutput("irq_cause", cause, 32'h100);
        checkOutput("irq_status", status, 32'h0103);
        applyStimulus(0, 32'h84, NOP, 0, 0, 0, 4'b0001, 0, 0);
        checkOutput("irq_in_handler_pcsrc", {30'd0, pcsrc}, 0);
        applyStimulus(0, 32'h88, ERET, 0, 0, 0, 4'b0000, 0, 0);
        checkOutput("irq_eret_pcsrc", {30'd0, pcsrc}, 2);
        applyStimulus(0, 32'h24, NOP, 0, 0, 0, 0, 1, 0);
        checkOutput("irq_return_pcsrc", {30'd0, pcsrc}, 0);

        // Overflow beats a taken branch
        applyStimulus(0, 32'h30, NOP, 1, 32'h200, 1, 0, 0, 0);
        checkOutput("ovf_pcsrc", {30'd0, pcsrc}, 3);
        applyStimulus(0, 32'h80, NOP, 0, 0, 0, 0, 0, 0);
        checkOutput("ovf_cause", cause, 32'h30);
        checkOutput("ovf_epc", epc, 32'h30);

        // Reset while in handler
        applyStimulus(0, 32'h90, ERET, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 32'h40, SYS, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 32'h80, NOP, 0, 0, 0, 0, 0, 0);
        checkOutput("pre_rst_epc", epc, 32'h40);
        applyStimulus(1, 32'h84, NOP, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 32'h0, NOP, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_in_handler", {31'd0, in_handler}, 0);
        checkOutput("rst_epc", epc, 0);
        checkOutput("rst_pcsrc", {30'd0, pcsrc}, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 2)      ins = {6'd0, 20'($urandom), 6'h0C};
            else if (sel < 4) ins = ERET;
            else              ins = $urandom;
            applyStimulus(($urandom_range(0, 99) == 0), {$urandom_range(0, 1023), 2'b00}, ins,
                          ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 11) == 0),
                          NUM_IRQ'($urandom), ($urandom_range(0, 9) == 0), $urandom);
        end

        checking = 0;
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
